// File: rtl/alu_wb_buffer.sv
// ---------------------------------------------------------------------------
// alu_wb_buffer
//
// Writeback-side companion of the ALU. Each ALU result (result, branch
// outcome and scoreboard transaction id) is captured into a small in-order
// buffer. It is held there until the scoreboard writeback port accepts it.
// Valid/ready handshakes on both sides decouple combinational ALU issue from
// writeback-port arbitration.
//
// Optional feature macro: ALU_WB_BYPASS_EN
//   When defined, an empty buffer forwards the ALU input combinationally to
//   the writeback port. If the port accepts in the same cycle, the op
//   completes with zero latency and is never stored.
//   When undefined, there is no combinational alu_* -> wb_* path and the
//   minimum latency is one cycle.
//
// Parameters
//   XLEN           result width
//   TRANS_ID_BITS  scoreboard transaction id width
//   DEPTH          buffer entries (power of two, >= 2)
//
// Ports
//   clk_i            in   clock
//   rst_i            in   asynchronous reset, active-high
//   flush_i          in   squash all buffered entries
//   alu_valid_i      in   ALU result valid this cycle
//   alu_ready_o      out  buffer can accept an ALU result
//   alu_trans_id_i   in   id of the issued op
//   alu_result_i     in   ALU result
//   alu_branch_res_i in   ALU branch outcome
//   wb_valid_o       out  head entry valid
//   wb_ready_i       in   writeback port accepts the head entry
//   wb_trans_id_o    out  head id
//   wb_result_o      out  head result
//   wb_branch_res_o  out  head branch outcome
//   count_o          out  number of occupied entries
// ---------------------------------------------------------------------------
module alu_wb_buffer #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned DEPTH         = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     alu_valid_i,
    output logic                     alu_ready_o,
    input  logic [TRANS_ID_BITS-1:0] alu_trans_id_i,
    input  logic [XLEN-1:0]          alu_result_i,
    input  logic                     alu_branch_res_i,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [XLEN-1:0]          wb_result_o,
    output logic                     wb_branch_res_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Occupancy view of the buffer. It is kept alongside the counter so that
    // the handshake outputs come straight from the state register.
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occState_e;

    occState_e              state_q, state_d;
    logic [PTR_W-1:0]       wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]       rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic [TRANS_ID_BITS-1:0] idMem_q     [DEPTH];
    logic [XLEN-1:0]          resultMem_q [DEPTH];
    logic                     branchMem_q [DEPTH];

    logic headValid;
    logic hasRoom;
    logic bypassActive;
    logic bypassTaken;
    logic pushEn;
    logic popEn;

    assign headValid = (state_q != OCC_EMPTY);
    assign hasRoom   = (state_q != OCC_FULL);

    // A pop in the same cycle frees a slot, so a full buffer still accepts
    // when the writeback port is ready. flush_i does not affect readiness.
    assign alu_ready_o = hasRoom | wb_ready_i;

`ifdef ALU_WB_BYPASS_EN
    // Forwarding applies only while nothing is buffered, so FIFO order is
    // never violated by a younger op overtaking an older stored one.
    assign bypassActive = (state_q == OCC_EMPTY) & ~flush_i;
    assign bypassTaken  = bypassActive & alu_valid_i & wb_ready_i;
`else
    assign bypassActive = 1'b0;
    assign bypassTaken  = 1'b0;
`endif

    // Flush wins over both push and pop; an op consumed by the bypass path
    // completes immediately and must not also be stored.
    assign pushEn = alu_valid_i & alu_ready_o & ~bypassTaken & ~flush_i;
    assign popEn  = headValid & wb_ready_i & ~flush_i;

    // Writeback outputs come from the head entry, or from the ALU input when
    // the bypass path is active. Storage is cleared on reset, so the head
    // reads zero straight out of reset.
    always_comb begin
        wb_valid_o      = headValid;
        wb_trans_id_o   = idMem_q[rdPtr_q];
        wb_result_o     = resultMem_q[rdPtr_q];
        wb_branch_res_o = branchMem_q[rdPtr_q];
        if (bypassActive) begin
            wb_valid_o      = alu_valid_i;
            wb_trans_id_o   = alu_trans_id_i;
            wb_result_o     = alu_result_i;
            wb_branch_res_o = alu_branch_res_i;
        end
    end

    assign count_o = count_q;

    // Next-state logic for pointers, counter and occupancy state. Pointers
    // are exactly PTR_W bits wide, so the increments wrap modulo DEPTH.
    always_comb begin
        state_d = state_q;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;

        if (flush_i) begin
            state_d = OCC_EMPTY;
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (pushEn) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (popEn) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            if (pushEn && !popEn) begin
                count_d = count_q + CNT_W'(1);
            end else if (popEn && !pushEn) begin
                count_d = count_q - CNT_W'(1);
            end

            unique case (state_q)
                OCC_EMPTY: begin
                    if (pushEn) begin
                        state_d = OCC_PARTIAL;
                    end
                end
                OCC_PARTIAL: begin
                    if (pushEn && !popEn && count_q == CNT_W'(DEPTH - 1)) begin
                        state_d = OCC_FULL;
                    end else if (popEn && !pushEn && count_q == CNT_W'(1)) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (popEn && !pushEn) begin
                        state_d = OCC_PARTIAL;
                    end
                end
                default: begin
                    state_d = OCC_EMPTY;
                end
            endcase
        end
    end

    // Control registers: occupancy state, pointers and counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= OCC_EMPTY;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage. Only the slot at the write pointer changes on a push;
    // stale contents of popped slots are harmless because wb_valid_o is
    // driven from the occupancy state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                idMem_q[i]     <= '0;
                resultMem_q[i] <= '0;
                branchMem_q[i] <= 1'b0;
            end
        end else if (pushEn) begin
            idMem_q[wrPtr_q]     <= alu_trans_id_i;
            resultMem_q[wrPtr_q] <= alu_result_i;
            branchMem_q[wrPtr_q] <= alu_branch_res_i;
        end
    end

    // The ALU must honour alu_ready_o, and the counter can never exceed the
    // buffer depth.
    assert property (@(posedge clk_i) disable iff (rst_i)
                     !(alu_valid_i && !alu_ready_o))
        else $error("alu_wb_buffer: ALU issued while alu_ready_o was low");

    assert property (@(posedge clk_i) disable iff (rst_i)
                     count_q <= CNT_W'(DEPTH))
        else $error("alu_wb_buffer: occupancy exceeds DEPTH");

endmodule

// File: tb/tb_alu_wb_buffer.sv
// ---------------------------------------------------------------------------
// tb_alu_wb_buffer
//
// Directed bench for alu_wb_buffer in its default build (bypass disabled,
// DEPTH=2). Inputs change on the falling clock edge and outputs are checked
// 1ns later, so each check sees the state left by the previous rising edge.
// ---------------------------------------------------------------------------
module tb_alu_wb_buffer;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        aluValid;
   logic        aluReady;
   logic [2:0]  aluTransId;
   logic [63:0] aluResult;
   logic        aluBranchRes;
   logic        wbValid;
   logic        wbReady;
   logic [2:0]  wbTransId;
   logic [63:0] wbResult;
   logic        wbBranchRes;
   logic [1:0]  count;

   int checkCount = 0;
   int passCount  = 0;

   alu_wb_buffer #(
      .XLEN(64),
      .TRANS_ID_BITS(3),
      .DEPTH(2)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .flush_i(flush),
      .alu_valid_i(aluValid),
      .alu_ready_o(aluReady),
      .alu_trans_id_i(aluTransId),
      .alu_result_i(aluResult),
      .alu_branch_res_i(aluBranchRes),
      .wb_valid_o(wbValid),
      .wb_ready_i(wbReady),
      .wb_trans_id_o(wbTransId),
      .wb_result_o(wbResult),
      .wb_branch_res_o(wbBranchRes),
      .count_o(count)
   );

   // Free-running 10ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Waits for the falling edge, drives one cycle of inputs, then settles.
   task automatic applyStimulus(input logic v, input logic [2:0] id,
                                input logic [63:0] res, input logic br,
                                input logic wbr, input logic fl);
      @(negedge clk);
      aluValid     = v;
      aluTransId   = id;
      aluResult    = res;
      aluBranchRes = br;
      wbReady      = wbr;
      flush        = fl;
      #1;
   endtask

   // One comparison, counted and reported on mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   // Directed sequence: reset, back-to-back, backpressure, full with
   // simultaneous push/pop, branch bit, flush, and reset mid-stream.
   initial begin
      rst          = 1'b1;
      flush        = 1'b0;
      aluValid     = 1'b0;
      aluTransId   = '0;
      aluResult    = '0;
      aluBranchRes = 1'b0;
      wbReady      = 1'b0;
      #1;
      checkOutput("reset_wb_valid", 64'(wbValid), 64'd0);
      checkOutput("reset_alu_ready", 64'(aluReady), 64'd1);
      checkOutput("reset_count", 64'(count), 64'd0);
      checkOutput("reset_wb_id", 64'(wbTransId), 64'd0);
      checkOutput("reset_wb_result", wbResult, 64'd0);
      checkOutput("reset_wb_branch", 64'(wbBranchRes), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Back-to-back ids 1..4 with the writeback port always ready.
      applyStimulus(1'b1, 3'd1, 64'h11, 1'b0, 1'b1, 1'b0);
      checkOutput("b2b_no_same_cycle", 64'(wbValid), 64'd0);
      applyStimulus(1'b1, 3'd2, 64'h22, 1'b0, 1'b1, 1'b0);
      checkOutput("b2b_valid1", 64'(wbValid), 64'd1);
      checkOutput("b2b_id1", 64'(wbTransId), 64'd1);
      checkOutput("b2b_res1", wbResult, 64'h11);
      checkOutput("b2b_count", 64'(count), 64'd1);
      applyStimulus(1'b1, 3'd3, 64'h33, 1'b0, 1'b1, 1'b0);
      checkOutput("b2b_id2", 64'(wbTransId), 64'd2);
      applyStimulus(1'b1, 3'd4, 64'h44, 1'b0, 1'b1, 1'b0);
      checkOutput("b2b_id3", 64'(wbTransId), 64'd3);
      applyStimulus(1'b0, 3'd0, 64'h0, 1'b0, 1'b1, 1'b0);
      checkOutput("b2b_id4", 64'(wbTransId), 64'd4);
      checkOutput("b2b_res4", wbResult, 64'h44);
      applyStimulus(1'b0, 3'd0, 64'h0, 1'b0, 1'b1, 1'b0);
      checkOutput("b2b_drained_valid", 64'(wbValid), 64'd0);
      checkOutput("b2b_drained_count", 64'(count), 64'd0);

      // Backpressure: ids 5 and 6 stack up while the port is stalled.
      applyStimulus(1'b1, 3'd5, 64'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
      checkOutput("bp_empty_valid", 64'(wbValid), 64'd0);
      applyStimulus(1'b1, 3'd6, 64'h1, 1'b0, 1'b0, 1'b0);
      checkOutput("bp_one_id", 64'(wbTransId), 64'd5);
      checkOutput("bp_one_ready", 64'(aluReady), 64'd1);
      applyStimulus(1'b0, 3'd0, 64'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("bp_full_count", 64'(count), 64'd2);
      checkOutput("bp_full_ready", 64'(aluReady), 64'd0);
      checkOutput("bp_full_id", 64'(wbTransId), 64'd5);
      checkOutput("bp_full_res", wbResult, 64'hDEAD_BEEF);
      applyStimulus(1'b0, 3'd0, 64'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("bp_hold_valid", 64'(wbValid), 64'd1);
      checkOutput("bp_hold_id", 64'(wbTransId), 64'd5);

      // Full buffer with simultaneous pop and push of id 7.
      applyStimulus(1'b1, 3'd7, 64'h7, 1'b0, 1'b1, 1'b0);
      checkOutput("fs_ready", 64'(aluReady), 64'd1);
      applyStimulus(1'b0, 3'd0, 64'h0, 1'b0, 1'b1, 1'b0);
      checkOutput("fs_count", 64'(count), 64'd2);
      checkOutput("fs_id6", 64'(wbTransId), 64'd6);
      checkOutput("fs_res6", wbResult, 64'h1);
      applyStimulus(1'b0, 3'd0, 64'h0, 1'b0, 1'b1, 1'b0);
      checkOutput("fs_id7", 64'(wbTransId), 64'd7);
      checkOutput("fs_res7", wbResult, 64'h7);
      checkOutput("fs_count1", 64'(count), 64'd1);
      applyStimulus(1'b0, 3'd0, 64'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("fs_drained", 64'(wbValid), 64'd0);

      // Branch bit travels with its id.
      applyStimulus(1'b1, 3'd3, 64'h33, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'd2, 64'h22, 1'b0, 1'b0, 1'b0);
      checkOutput("br_valid", 64'(wbValid), 64'd1);
      checkOutput("br_id", 64'(wbTransId), 64'd3);
      checkOutput("br_bit", 64'(wbBranchRes), 64'd1);

      // Flush with two entries and a push in the flush cycle.
      applyStimulus(1'b1, 3'd6, 64'h66, 1'b0, 1'b1, 1'b1);
      checkOutput("fl_ready", 64'(aluReady), 64'd1);
      checkOutput("fl_pre_count", 64'(count), 64'd2);
      applyStimulus(1'b0, 3'd0, 64'h0, 1'b0, 1'b1, 1'b0);
      checkOutput("fl_count", 64'(count), 64'd0);
      checkOutput("fl_valid", 64'(wbValid), 64'd0);
      applyStimulus(1'b0, 3'd0, 64'h0, 1'b0, 1'b1, 1'b0);
      checkOutput("fl_dropped", 64'(wbValid), 64'd0);

      // Reset asserted with two entries buffered.
      applyStimulus(1'b1, 3'd1, 64'h11, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'd2, 64'h22, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'd0, 64'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("mr_pre_count", 64'(count), 64'd2);
      rst = 1'b1;
      #1;
      checkOutput("mr_valid", 64'(wbValid), 64'd0);
      checkOutput("mr_count", 64'(count), 64'd0);
      checkOutput("mr_ready", 64'(aluReady), 64'd1);
      checkOutput("mr_id", 64'(wbTransId), 64'd0);
      checkOutput("mr_res", wbResult, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
